decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction decode stage for the colouring-solver CPU, sitting between fetch and execute. It decodes the same 16-opcode instruction set, with field widths scaled by parameters. It adds a valid/ready handshake on both sides, a register scoreboard for RAW/WAW hazards, a zero-flag interlock for JNZ, and a registered branch redirect to fetch. Fields an opcode does not use are driven to zero, so no state is inherited from earlier instructions.

## Interface
- REG_AW, 4: register address width; instruction width INSN_W = 4 + 3*REG_AW.
- PC_W, 6: program counter width; must be <= 3*REG_AW.
- IMM_W derived = 2*REG_AW: immediate width (8 at default).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_insn  in  INSN_W  instruction; opcode in the top 4 bits, fields A/B/C follow (each REG_AW bits, A highest).
- in_ready  out  1  instruction accepted this cycle; combinational from state and in_insn.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- alu_op  out  4  opcode.
- src0, src1, dst  out  REG_AW each  register addresses.
- data  out  IMM_W  immediate.
- sel1, sel2, reg_we, mem_we  out  1 each  datapath controls.
- wb_valid  in  1  writeback retires a register write.
- wb_dst  in  REG_AW  register retired.
- zf_valid  in  1  execute reports a flag result.
- zf  in  1  flag value; sampled only when zf_valid=1.
- redirect_valid  out  1  one-cycle branch-taken pulse.
- redirect_pc  out  PC_W  branch target.

## Operation
Field mapping by opcode class:
- SUB/MUL/DIV: src0=A, src1=B, dst=C; sel1=1, reg_we=1.
- INC/DEC: src0=A, dst=B; sel1=1, reg_we=1.
- COMPARE, CHECK_COLOR: src0=A, src1=B; sel1=1.
- CHECK, CHECK_MAP: src1=A, data={B,C}.
- LOAD: src1=A, dst=B; sel2=1, reg_we=1.
- STORE: src1=A, src0=B; sel1=1, mem_we=1.
- LI: data={A,B}, dst=C; reg_we=1.
- SEPARATE1/2: src1=A, dst=B; reg_we=1.
- JMP/JNZ: target = top PC_W bits of {A,B,C}. Consumed in decode; they produce no out beat.
- Every control or field not listed for a class is 0.

Scoreboard:
- pend[2^REG_AW] bits.
- Issuing a reg_we op sets pend[dst].
- wb_valid clears pend[wb_dst]; a clear to a non-pending register is a no-op.
- Set and clear of the same register in the same cycle: set wins.

Flag counter:
- fcnt, 2 bits; counts issued COMPARE/CHECK/CHECK_COLOR/CHECK_MAP ops whose flag has not yet been reported.
- Increment on issue of a flag producer; decrement on zf_valid; both in one cycle leave it unchanged.
- Every zf_valid loads zflag with zf.

Stall (in_ready=0) when any of the following holds:
- redirect_valid=1.
- out_valid=1 and out_ready=0, for non-jump instructions.
- A used source register has its pend bit set.
- The reg_we op's dst has its pend bit set.
- A flag producer is presented while fcnt=3.
- JNZ is presented while fcnt!=0.

Branches:
- JMP is always taken.
- JNZ is taken when zflag=1.
- A not-taken JNZ is consumed silently.

Fetch must discard any instruction it presents during a redirect cycle, and present the target next.

## Timing
- Accept at edge N gives out_valid and fields from edge N; latency is 1 cycle.
- The out bundle holds stable while out_valid=1 and out_ready=0.
- Back-to-back throughput is 1 instruction per cycle when out_ready=1 and there are no hazards.
- A taken branch accepted at edge N drives redirect_valid=1 and redirect_pc from edge N for exactly one cycle. in_ready=0 during that cycle, so a taken branch costs 1 bubble.
- JNZ uses zflag as registered. A zf_valid arriving in the same cycle as a JNZ does not release the stall; the JNZ can be accepted the following cycle.
- Reset, asynchronous at any time, forces:
  - out_valid=0, all fields and controls 0;
  - redirect_valid=0, redirect_pc=0;
  - pend all 0, fcnt=0, zflag=0.

## Test plan
- LI 0x2A to r3, then SUB r3,r1→r4 back-to-back with no writeback: LI out 1 cycle after accept (data=0x2A, dst=3, reg_we=1). SUB is held (in_ready=0) until wb_valid with wb_dst=3, and issues the cycle after.
- Hold out_ready=0 with a STORE in the out register: the bundle stays stable (mem_we=1, src1=A, src0=B), in_ready=0, and the next insn issues on the release edge.
- COMPARE, then zf_valid=1 with zf=1, then JNZ target 0x15: JNZ stalls while fcnt=1, then redirect_valid pulses for one cycle with redirect_pc=0x15 and produces no out beat. Repeating with zf=0 gives no redirect.
- Four consecutive CHECK ops with no zf_valid: three issue, the fourth stalls until a zf_valid arrives.
- Issue an INC, then assert rst mid-stall: all outputs drop to 0 asynchronously and pend is cleared. After release, a dependent op issues without a writeback.
- Each opcode issued: every field not listed for its class reads 0; check that each class's sel1/sel2/reg_we/mem_we match the mapping.

Source files
------------

// File: rtl/decode_stage.sv
// Registered decode stage: splits instructions into datapath fields, tracks
// RAW/WAW hazards with a pending-write scoreboard and resolves JMP/JNZ locally.
module decode_stage #(
  parameter int REG_AW = 4,
  parameter int PC_W   = 6,
  localparam int INSN_W = 4 + 3 * REG_AW,
  localparam int IMM_W  = 2 * REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INSN_W-1:0] in_insn,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] src0,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] dst,
  output logic [IMM_W-1:0]  data,
  output logic              sel1,
  output logic              sel2,
  output logic              reg_we,
  output logic              mem_we,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              zf_valid,
  input  logic              zf,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc
);

  typedef enum logic [3:0] {
    OP_SUB       = 4'd0,
    OP_MUL       = 4'd1,
    OP_DIV       = 4'd2,
    OP_INC       = 4'd3,
    OP_DEC       = 4'd4,
    OP_COMPARE   = 4'd5,
    OP_CHECK_COL = 4'd6,
    OP_CHECK     = 4'd7,
    OP_CHECK_MAP = 4'd8,
    OP_LOAD      = 4'd9,
    OP_STORE     = 4'd10,
    OP_LI        = 4'd11,
    OP_SEP1      = 4'd12,
    OP_SEP2      = 4'd13,
    OP_JMP       = 4'd14,
    OP_JNZ       = 4'd15
  } opcode_t;

  opcode_t             op;
  logic [REG_AW-1:0]   fa, fb, fc;
  logic [PC_W-1:0]     target;

  logic [REG_AW-1:0]   d_src0, d_src1, d_dst;
  logic [IMM_W-1:0]    d_data;
  logic                d_sel1, d_sel2, d_reg_we, d_mem_we;
  logic                use0, use1, flag_prod, is_jump, taken;

  logic [2**REG_AW-1:0] pend;
  logic [1:0]           fcnt;
  logic                 zflag;
  logic                 stall, accept, inc, dec;

  assign op     = opcode_t'(in_insn[INSN_W-1 -: 4]);
  assign fa     = in_insn[3*REG_AW-1 -: REG_AW];
  assign fb     = in_insn[2*REG_AW-1 -: REG_AW];
  assign fc     = in_insn[REG_AW-1:0];
  assign target = in_insn[3*REG_AW-1 -: PC_W];

  // Field mapping per opcode class; anything a class does not use stays 0.
  always_comb begin
    d_src0    = '0;
    d_src1    = '0;
    d_dst     = '0;
    d_data    = '0;
    d_sel1    = 1'b0;
    d_sel2    = 1'b0;
    d_reg_we  = 1'b0;
    d_mem_we  = 1'b0;
    use0      = 1'b0;
    use1      = 1'b0;
    flag_prod = 1'b0;
    is_jump   = 1'b0;
    case (op)
      OP_SUB, OP_MUL, OP_DIV: begin
        d_src0 = fa; d_src1 = fb; d_dst = fc;
        d_sel1 = 1'b1; d_reg_we = 1'b1; use0 = 1'b1; use1 = 1'b1;
      end
      OP_INC, OP_DEC: begin
        d_src0 = fa; d_dst = fb;
        d_sel1 = 1'b1; d_reg_we = 1'b1; use0 = 1'b1;
      end
      OP_COMPARE, OP_CHECK_COL: begin
        d_src0 = fa; d_src1 = fb;
        d_sel1 = 1'b1; use0 = 1'b1; use1 = 1'b1; flag_prod = 1'b1;
      end
      OP_CHECK, OP_CHECK_MAP: begin
        d_src1 = fa; d_data = {fb, fc};
        use1 = 1'b1; flag_prod = 1'b1;
      end
      OP_LOAD: begin
        d_src1 = fa; d_dst = fb;
        d_sel2 = 1'b1; d_reg_we = 1'b1; use1 = 1'b1;
      end
      OP_STORE: begin
        d_src1 = fa; d_src0 = fb;
        d_sel1 = 1'b1; d_mem_we = 1'b1; use0 = 1'b1; use1 = 1'b1;
      end
      OP_LI: begin
        d_data = {fa, fb}; d_dst = fc; d_reg_we = 1'b1;
      end
      OP_SEP1, OP_SEP2: begin
        d_src1 = fa; d_dst = fb; d_reg_we = 1'b1; use1 = 1'b1;
      end
      default: is_jump = 1'b1;
    endcase
  end

  // Jumps never occupy the out register, so backpressure does not hold them.
  always_comb begin
    stall = redirect_valid
          | (!is_jump && out_valid && !out_ready)
          | (use0 && pend[d_src0])
          | (use1 && pend[d_src1])
          | (d_reg_we && pend[d_dst])
          | (flag_prod && fcnt == 2'd3)
          | (op == OP_JNZ && fcnt != 2'd0);
  end

  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign taken    = (op == OP_JMP) || (op == OP_JNZ && zflag);
  assign inc      = accept && flag_prod;
  assign dec      = zf_valid && fcnt != 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_op    <= '0;
      src0      <= '0;
      src1      <= '0;
      dst       <= '0;
      data      <= '0;
      sel1      <= 1'b0;
      sel2      <= 1'b0;
      reg_we    <= 1'b0;
      mem_we    <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (accept && !is_jump) begin
        out_valid <= 1'b1;
        alu_op    <= op;
        src0      <= d_src0;
        src1      <= d_src1;
        dst       <= d_dst;
        data      <= d_data;
        sel1      <= d_sel1;
        sel2      <= d_sel2;
        reg_we    <= d_reg_we;
        mem_we    <= d_mem_we;
      end else begin
        out_valid <= 1'b0;
        alu_op    <= '0;
        src0      <= '0;
        src1      <= '0;
        dst       <= '0;
        data      <= '0;
        sel1      <= 1'b0;
        sel2      <= 1'b0;
        reg_we    <= 1'b0;
        mem_we    <= 1'b0;
      end
    end
  end

  // Redirect is a single-cycle pulse; the target is only meaningful with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept && taken;
      redirect_pc    <= (accept && taken) ? target : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      fcnt  <= 2'd0;
      zflag <= 1'b0;
    end else begin
      pend <= (pend & ~(wb_valid ? ({{(2**REG_AW-1){1'b0}}, 1'b1} << wb_dst) : '0))
            | ((accept && d_reg_we) ? ({{(2**REG_AW-1){1'b0}}, 1'b1} << d_dst) : '0);
      if (inc && !dec)
        fcnt <= fcnt + 2'd1;
      else if (dec && !inc)
        fcnt <= fcnt - 2'd1;
      if (zf_valid)
        zflag <= zf;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hazards, backpressure, branches, flag
// interlock, async reset and the per-opcode field mapping.
module tb_decode_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_insn;
  logic [3:0]  alu_op, src0, src1, dst, wb_dst;
  logic [7:0]  data;
  logic        sel1, sel2, reg_we, mem_we;
  logic        wb_valid, zf_valid, zf, redirect_valid;
  logic [5:0]  redirect_pc;

  int tests_run = 0;
  int tests_failed = 0;

  // {out_valid, alu_op, src0, src1, dst, data, sel1, sel2, reg_we, mem_we}
  logic [28:0] bundle;
  assign bundle = {out_valid, alu_op, src0, src1, dst, data, sel1, sel2, reg_we, mem_we};

  decode_stage #(.REG_AW(4), .PC_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_insn(in_insn), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .src0(src0),
    .src1(src1), .dst(dst), .data(data), .sel1(sel1), .sel2(sel2), .reg_we(reg_we),
    .mem_we(mem_we), .wb_valid(wb_valid), .wb_dst(wb_dst), .zf_valid(zf_valid), .zf(zf),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk_insn(input logic [3:0] op, a, b, c);
    return {op, a, b, c};
  endfunction

  function automatic logic [28:0] mk_b(input logic v, input logic [3:0] op, s0, s1, d,
                                       input logic [7:0] dat, input logic [3:0] ctl);
    return {v, op, s0, s1, d, dat, ctl};
  endfunction

  // Expected bundle for each non-jump opcode with fields A=1, B=2, C=3.
  function automatic logic [28:0] exp_bundle(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2: return mk_b(1'b1, op, 4'd1, 4'd2, 4'd3, 8'h00, 4'b1010);
      4'd3, 4'd4:       return mk_b(1'b1, op, 4'd1, 4'd0, 4'd2, 8'h00, 4'b1010);
      4'd5, 4'd6:       return mk_b(1'b1, op, 4'd1, 4'd2, 4'd0, 8'h00, 4'b1000);
      4'd7, 4'd8:       return mk_b(1'b1, op, 4'd0, 4'd1, 4'd0, 8'h23, 4'b0000);
      4'd9:             return mk_b(1'b1, op, 4'd0, 4'd1, 4'd2, 8'h00, 4'b0110);
      4'd10:            return mk_b(1'b1, op, 4'd2, 4'd1, 4'd0, 8'h00, 4'b1001);
      4'd11:            return mk_b(1'b1, op, 4'd0, 4'd0, 4'd3, 8'h12, 4'b0010);
      default:          return mk_b(1'b1, op, 4'd0, 4'd1, 4'd2, 8'h00, 4'b0010);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_insn = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_dst = '0; zf_valid = 1'b0; zf = 1'b0;
    #12;
    tests_run++;
    if (bundle !== 29'd0) begin
      tests_failed++; $display("[TB] FAIL reset_bundle: got %h want 0", bundle);
    end
    tests_run++;
    if ({redirect_valid, redirect_pc} !== 7'd0) begin
      tests_failed++; $display("[TB] FAIL reset_redirect: got %b/%h want 0/0", redirect_valid, redirect_pc);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    #10 rst = 1'b0;
    tick();
  endtask

  task automatic test_li_sub();
    in_valid = 1'b1; in_insn = mk_insn(4'd11, 4'h2, 4'hA, 4'd3);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL li_accept: got %b want 1", in_ready);
    end
    tick();
    in_insn = mk_insn(4'd0, 4'd3, 4'd1, 4'd4);
    #1;
    tests_run++;
    if (bundle !== mk_b(1'b1, 4'd11, 4'd0, 4'd0, 4'd3, 8'h2A, 4'b0010)) begin
      tests_failed++; $display("[TB] FAIL li_bundle: got %h want %h", bundle, mk_b(1'b1, 4'd11, 4'd0, 4'd0, 4'd3, 8'h2A, 4'b0010));
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL sub_raw_stall: got %b want 0", in_ready);
    end
    tick();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL sub_still_held: got %b want 00", {out_valid, in_ready});
    end
    wb_valid = 1'b1; wb_dst = 4'd3;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL sub_wb_same_cycle: got %b want 0", in_ready);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL sub_released: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (bundle !== mk_b(1'b1, 4'd0, 4'd3, 4'd1, 4'd4, 8'h00, 4'b1010)) begin
      tests_failed++; $display("[TB] FAIL sub_bundle: got %h want %h", bundle, mk_b(1'b1, 4'd0, 4'd3, 4'd1, 4'd4, 8'h00, 4'b1010));
    end
    wb_valid = 1'b1; wb_dst = 4'd4;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = mk_insn(4'd10, 4'd5, 4'd6, 4'd7);
    tick();
    in_insn = mk_insn(4'd9, 4'd1, 4'd2, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({in_ready, bundle} !== {1'b0, mk_b(1'b1, 4'd10, 4'd6, 4'd5, 4'd0, 8'h00, 4'b1001)}) begin
        tests_failed++; $display("[TB] FAIL store_hold_%0d: got %b/%h want 0/%h", i, in_ready, bundle, mk_b(1'b1, 4'd10, 4'd6, 4'd5, 4'd0, 8'h00, 4'b1001));
      end
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL store_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (bundle !== mk_b(1'b1, 4'd9, 4'd0, 4'd1, 4'd2, 8'h00, 4'b0110)) begin
      tests_failed++; $display("[TB] FAIL load_after_release: got %h want %h", bundle, mk_b(1'b1, 4'd9, 4'd0, 4'd1, 4'd2, 8'h00, 4'b0110));
    end
    wb_valid = 1'b1; wb_dst = 4'd2;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_jnz(input logic flag);
    in_valid = 1'b1; in_insn = mk_insn(4'd5, 4'd1, 4'd2, 4'd0);
    tick();
    in_insn = mk_insn(4'd15, 4'd5, 4'd4, 4'd0);
    zf_valid = 1'b1; zf = flag;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL jnz_fcnt_stall_zf%0b: got %b want 0", flag, in_ready);
    end
    tick();
    zf_valid = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL jnz_ready_zf%0b: got %b want 10", flag, {in_ready, out_valid});
    end
    tick();
    in_insn = mk_insn(4'd0, 4'd7, 4'd7, 4'd7);
    #1;
    tests_run++;
    if ({redirect_valid, redirect_pc, out_valid, in_ready} !== (flag ? {1'b1, 6'h15, 1'b0, 1'b0} : {1'b0, 6'h00, 1'b0, 1'b1})) begin
      tests_failed++; $display("[TB] FAIL jnz_redirect_zf%0b: got %b/%h/%b/%b", flag, redirect_valid, redirect_pc, out_valid, in_ready);
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if ({redirect_valid, out_valid} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL jnz_pulse_end_zf%0b: got %b want 00", flag, {redirect_valid, out_valid});
    end
  endtask

  task automatic test_jmp();
    in_valid = 1'b1; in_insn = mk_insn(4'd14, 4'hF, 4'hF, 4'hF);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({redirect_valid, redirect_pc, out_valid} !== {1'b1, 6'h3F, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL jmp_redirect: got %b/%h/%b want 1/3f/0", redirect_valid, redirect_pc, out_valid);
    end
    tick();
  endtask

  task automatic test_flag_stall();
    in_valid = 1'b1; in_insn = mk_insn(4'd7, 4'd1, 4'd2, 4'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL check_issue_%0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL check_fourth_stall: got %b want 0", in_ready);
    end
    zf_valid = 1'b1; zf = 1'b0;
    tick();
    zf_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL check_fourth_release: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (bundle !== mk_b(1'b1, 4'd7, 4'd0, 4'd1, 4'd0, 8'h23, 4'b0000)) begin
      tests_failed++; $display("[TB] FAIL check_fourth_bundle: got %h want %h", bundle, mk_b(1'b1, 4'd7, 4'd0, 4'd1, 4'd0, 8'h23, 4'b0000));
    end
    zf_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    zf_valid = 1'b0;
  endtask

  task automatic test_all_opcodes();
    logic [28:0] exp;
    for (int i = 0; i < 14; i++) begin
      exp = exp_bundle(4'(i));
      in_valid = 1'b1; in_insn = mk_insn(4'(i), 4'd1, 4'd2, 4'd3);
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (bundle !== exp) begin
        tests_failed++; $display("[TB] FAIL opcode_%0d_map: got %h want %h", i, bundle, exp);
      end
      wb_valid = 1'b1; wb_dst = exp[15:12]; zf_valid = 1'b1;
      tick();
      wb_valid = 1'b0; zf_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_insn = mk_insn(4'd3, 4'd1, 4'd5, 4'd0);
    tick();
    out_ready = 1'b0;
    in_insn = mk_insn(4'd0, 4'd5, 4'd0, 4'd6);
    #1;
    tests_run++;
    if ({in_ready, bundle} !== {1'b0, mk_b(1'b1, 4'd3, 4'd1, 4'd0, 4'd5, 8'h00, 4'b1010)}) begin
      tests_failed++; $display("[TB] FAIL inc_before_reset: got %b/%h", in_ready, bundle);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bundle, redirect_valid, in_ready} !== {29'd0, 1'b0, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL async_reset_clear: got %h/%b/%b want 0/0/1", bundle, redirect_valid, in_ready);
    end
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (bundle !== mk_b(1'b1, 4'd0, 4'd5, 4'd0, 4'd6, 8'h00, 4'b1010)) begin
      tests_failed++; $display("[TB] FAIL dep_after_reset: got %h want %h", bundle, mk_b(1'b1, 4'd0, 4'd5, 4'd0, 4'd6, 8'h00, 4'b1010));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_li_sub();
    test_backpressure();
    test_jnz(1'b1);
    test_jnz(1'b0);
    test_jmp();
    test_flag_stall();
    test_all_opcodes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
